// File: rtl/cpu_pkg.sv
// Types and constants shared between the 3-bit CPU and its output-port FIFO.
package cpu_pkg;

    localparam int DATA_WIDTH = 3;

    typedef logic [DATA_WIDTH-1:0] out_word_t;

endpackage : cpu_pkg

// File: rtl/cpu_output_fifo_if.sv
// Push/drain/status bundle between the CPU output port, the FIFO and its consumer.
interface cpu_output_fifo_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                wr_en;
    out_word_t           wr_data;
    logic                rd_valid;
    logic                rd_ready;
    out_word_t           rd_data;
    logic [ADDR_WIDTH:0] count;
    logic                full;
    logic                overflow;
    logic                clear_ovf;

    modport master (
        output wr_en, wr_data, rd_ready, clear_ovf,
        input  rd_valid, rd_data, count, full, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_ready, clear_ovf,
        output rd_valid, rd_data, count, full, overflow
    );

endinterface : cpu_output_fifo_if

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer; wraps modulo 2**ADDR_WIDTH through natural overflow.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    logic [ADDR_WIDTH-1:0] ptr_r;

    // Pointer register: cleared asynchronously, advances by one when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {ADDR_WIDTH{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + ADDR_WIDTH'(1'b1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule : fifo_ptr

// File: rtl/cpu_output_fifo.sv
// Buffers CPU output-port writes for a slower valid/ready consumer and flags
// any value dropped while full with a sticky overflow bit.
module cpu_output_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH      = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_output_fifo_if.slave         bus
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1'b1);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

    out_word_t             mem_r [DEPTH];
    logic [ADDR_WIDTH:0]   count_r;
    logic                  overflow_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_s;
    logic                  rd_valid_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    out_word_t             rd_data_s;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_s),
        .ptr   (wr_ptr_s)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_s),
        .ptr   (rd_ptr_s)
    );

    // Handshake decode; a pop in the same cycle frees a slot for a push when full.
    always_comb begin
        rd_valid_s = (count_r != CNT_ZERO);
        full_s     = (count_r == CNT_FULL);
        pop_s      = rd_valid_s && bus.rd_ready;
        push_s     = bus.wr_en && (!full_s || pop_s);
        drop_s     = bus.wr_en && full_s && !pop_s;
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_s] <= bus.wr_data;
        end
    end

    // Occupancy counter; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clear_ovf keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.clear_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Head entry, forced to zero while empty so stale storage never leaks out.
    always_comb begin
        if (rd_valid_s) begin
            rd_data_s = mem_r[rd_ptr_s];
        end else begin
            rd_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign bus.rd_valid = rd_valid_s;
    assign bus.rd_data  = rd_data_s;
    assign bus.count    = count_r;
    assign bus.full     = full_s;
    assign bus.overflow = overflow_r;

endmodule : cpu_output_fifo

// File: doc/cpu_output_fifo.md
Name: cpu_output_fifo

Overview:
Buffers the values the 3-bit CPU writes to its output port so a slower downstream consumer (display or host link) never misses one. The CPU pushes a value with a one-cycle write strobe. The consumer drains values through a valid/ready handshake. A sticky flag records any value dropped because the buffer was full.

Parameters:
DATA_WIDTH, 3, width of each stored output value; matches the CPU output_data width.
DEPTH, 4, number of entries; must be a power of 2 and at least 2.
ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; named "reset" as elsewhere in the codebase, but asserted when 0.
wr_en  input  1  CPU push strobe; one value per cycle while high.
wr_data  input  DATA_WIDTH  CPU output value; sampled when wr_en is high.
rd_valid  output  1  high whenever the FIFO holds at least one entry.
rd_ready  input  1  consumer accepts the head entry this cycle.
rd_data  output  DATA_WIDTH  head entry; stable while rd_valid is high and rd_ready is low.
count  output  ADDR_WIDTH+1  number of entries held, 0..DEPTH.
full  output  1  high when count == DEPTH.
overflow  output  1  sticky: a push was dropped.
clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset == 0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Therefore rd_valid=0, full=0, rd_data=0. Storage array contents are don't-care, but rd_data is gated to 0 while the FIFO is empty.
- pop = rd_valid && rd_ready.
- push = wr_en && (!full || pop). When full, a simultaneous pop frees the slot, so that push is accepted.
- Accepted push: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- rd_data = mem[rd_ptr], combinational from the registered array. rd_valid = (count != 0).
- Write-to-read latency is 1 cycle: a value pushed at edge N is visible on rd_data with rd_valid high after edge N.
- Push into an empty FIFO: rd_valid is 0 in the same cycle, so there is no pop and no bypass.
- Dropped push: wr_en && full && !pop. The data is discarded, storage and pointers are unchanged, and overflow <= 1.
- overflow update:
  - Stays 1 until clear_ovf is sampled high.
  - If clear_ovf and a drop occur in the same cycle, the set wins and overflow stays 1.
- rd_ready while empty has no effect.
- Reset mid-operation: all entries are discarded immediately. Outputs take reset values asynchronously without waiting for clk.
- No combinational path from wr_en to rd_valid or rd_data. The only combinational input-to-output dependency is rd_ready into push acceptance, which is internal.

Decomposition:
- Shared package cpu_pkg: DATA_WIDTH default constant (3), shared with the cpu module, and an out_word_t typedef of DATA_WIDTH bits.
- One natural sub-module: fifo_ptr, a wrap-around pointer register with async active-low reset and an increment enable. It is instantiated twice, for wr_ptr and rd_ptr.
- Count and overflow logic stay in the top module.

Test Plan:
1. Reset then idle: assert reset=0 for 2 cycles, release, hold wr_en=0 -> rd_valid=0, count=0, full=0, overflow=0, rd_data=0.
2. Order and latency: push 5, 2, 7 on consecutive cycles with rd_ready=0 -> count=3. rd_valid rises one cycle after the first push with rd_data=5. Then set rd_ready=1 -> rd_data sequence is 5, 2, 7, then rd_valid=0 and count=0.
3. Fill and overflow: push 1, 2, 3, 4 (full=1), then push 6 with rd_ready=0 -> overflow=1, count=4. Draining yields 1, 2, 3, 4 and 6 never appears.
4. Full with simultaneous push and pop: FIFO full holding 1, 2, 3, 4; push 6 with rd_ready=1 in the same cycle -> overflow stays 0, count stays 4, drain order is 2, 3, 4, 6.
5. Overflow clear priority: with overflow=1, assert clear_ovf plus a dropped push in the same cycle -> overflow stays 1. Next cycle, clear_ovf alone -> overflow=0.
6. Wrap and async reset: perform 10 push/pop pairs of values 0..7,0,1 so the pointers wrap -> data is correct in order. Then push 3 and 4, and drop reset mid-cycle -> count=0, rd_valid=0 immediately, before the next clk edge.
